tb_pzcorebus_id_allocator: RTL and testbench

Testbench-side ID scheduler for pzcorebus master BFMs. It owns the local ID pool of one master port and hands out free IDs to non-posted requesters in round-robin order. Each granted ID stays locked until the matching final response is reported back. Its outputs are the port-prefixed command ID and outstanding/idle status used to throttle and drain the BFM.

---
 rtl/tb_pzcorebus_id_allocator.sv | 117 +++++++++++
 tb/tb_tb_pzcorebus_id_allocator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tb_pzcorebus_id_allocator.sv
// Round-robin local ID pool for a pzcorebus master BFM: offers free IDs with the
// port prefix attached and keeps each granted ID locked until its final response returns.
module tb_pzcorebus_id_allocator #(
   parameter int ID_WIDTH             = 8,
   parameter int LOCAL_ID_WIDTH       = 4,
   parameter int PORT_ID_WIDTH        = ID_WIDTH - LOCAL_ID_WIDTH,
   parameter int ACTUAL_PORT_ID_WIDTH = (PORT_ID_WIDTH > 0) ? PORT_ID_WIDTH : 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [ACTUAL_PORT_ID_WIDTH-1:0] i_port_id,
   input  logic                            i_alloc_valid,
   output logic                            o_alloc_ready,
   output logic [ID_WIDTH-1:0]             o_alloc_id,
   input  logic                            i_release_valid,
   input  logic [ID_WIDTH-1:0]             i_release_id,
   input  logic                            i_clear_error,
   output logic [LOCAL_ID_WIDTH:0]         o_outstanding,
   output logic                            o_idle,
   output logic                            o_release_error
);

   localparam int N = 2 ** LOCAL_ID_WIDTH;

   logic [N-1:0]              busy;
   logic [N-1:0]              busy_next;
   logic [LOCAL_ID_WIDTH-1:0] ptr;
   logic [LOCAL_ID_WIDTH-1:0] offer_local;
   logic [LOCAL_ID_WIDTH-1:0] scan_idx;
   logic [LOCAL_ID_WIDTH-1:0] release_local;
   logic [LOCAL_ID_WIDTH:0]   outstanding;
   logic [LOCAL_ID_WIDTH:0]   outstanding_next;
   logic                      release_error;
   logic                      offer_found;
   logic                      port_match;
   logic                      release_legal;
   logic                      release_illegal;
   logic                      grant;

   // First free entry at or after ptr, wrapping; only registered state feeds the offer.
   always_comb begin
      offer_found = 1'b0;
      offer_local = ptr;
      scan_idx    = ptr;
      for (int k = 0; k < N; k++) begin
         scan_idx = ptr + LOCAL_ID_WIDTH'(k);
         if (!offer_found && !busy[scan_idx]) begin
            offer_local = scan_idx;
            offer_found = 1'b1;
         end
      end
   end

   generate
      if (PORT_ID_WIDTH > 0) begin : g_port
         assign o_alloc_id = (ID_WIDTH'(i_port_id) << LOCAL_ID_WIDTH) | ID_WIDTH'(offer_local);
         assign port_match = (i_release_id[ID_WIDTH-1:LOCAL_ID_WIDTH] == i_port_id);
      end else begin : g_noport
         logic unused_port_id;
         assign unused_port_id = ^i_port_id;
         assign o_alloc_id     = ID_WIDTH'(offer_local);
         assign port_match     = 1'b1;
      end
   endgenerate

   assign release_local   = i_release_id[LOCAL_ID_WIDTH-1:0];
   assign release_legal   = i_release_valid & port_match & busy[release_local];
   assign release_illegal = i_release_valid & ~release_legal;
   assign grant           = i_alloc_valid & offer_found;

   // A legal release never targets the offered entry, so both updates can apply together.
   always_comb begin
      busy_next = busy;
      if (release_legal) begin
         busy_next[release_local] = 1'b0;
      end
      if (grant) begin
         busy_next[offer_local] = 1'b1;
      end
   end

   always_comb begin
      outstanding_next = outstanding;
      case ({grant, release_legal})
         2'b10:   outstanding_next = outstanding + 1'b1;
         2'b01:   outstanding_next = outstanding - 1'b1;
         default: outstanding_next = outstanding;
      endcase
   end

   // Setting the error flag takes priority over a same-cycle clear.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         busy          <= '0;
         ptr           <= '0;
         outstanding   <= '0;
         release_error <= 1'b0;
      end else begin
         busy        <= busy_next;
         outstanding <= outstanding_next;
         if (grant) begin
            ptr <= offer_local + 1'b1;
         end
         if (release_illegal) begin
            release_error <= 1'b1;
         end else if (i_clear_error) begin
            release_error <= 1'b0;
         end
      end
   end

   assign o_alloc_ready   = offer_found;
   assign o_outstanding   = outstanding;
   assign o_idle          = (outstanding == '0);
   assign o_release_error = release_error;

endmodule

// File: tb/tb_tb_pzcorebus_id_allocator.sv
// Vector-table bench for the ID allocator: a 4-entry pool behind port prefix 2'b10,
// with per-cycle expectations queued as stimulus is driven and checked once outputs settle.
module tb_tb_pzcorebus_id_allocator;

   typedef struct {
      logic       rst_n;
      logic       alloc_valid;
      logic       release_valid;
      logic [3:0] release_id;
      logic       clear_error;
      logic       exp_ready;
      logic [3:0] exp_id;
      logic [2:0] exp_out;
      logic       exp_idle;
      logic       exp_err;
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [1:0] i_port_id;
   logic       i_alloc_valid;
   logic       o_alloc_ready;
   logic [3:0] o_alloc_id;
   logic       i_release_valid;
   logic [3:0] i_release_id;
   logic       i_clear_error;
   logic [2:0] o_outstanding;
   logic       o_idle;
   logic       o_release_error;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   vec_idx  = 0;
   vec_t tbl[$];
   vec_t scoreboard[$];

   always #5 i_clk = ~i_clk;

   tb_pzcorebus_id_allocator #(
      .ID_WIDTH       (4),
      .LOCAL_ID_WIDTH (2)
   ) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_port_id       (i_port_id),
      .i_alloc_valid   (i_alloc_valid),
      .o_alloc_ready   (o_alloc_ready),
      .o_alloc_id      (o_alloc_id),
      .i_release_valid (i_release_valid),
      .i_release_id    (i_release_id),
      .i_clear_error   (i_clear_error),
      .o_outstanding   (o_outstanding),
      .o_idle          (o_idle),
      .o_release_error (o_release_error)
   );

   function automatic vec_t mk(input logic alloc, input logic rel_v, input logic [3:0] rel_id,
                               input logic clr, input logic rst_n, input logic exp_ready,
                               input logic [3:0] exp_id, input logic [2:0] exp_out,
                               input logic exp_err);
      vec_t v;
      v.rst_n         = rst_n;
      v.alloc_valid   = alloc;
      v.release_valid = rel_v;
      v.release_id    = rel_id;
      v.clear_error   = clr;
      v.exp_ready     = exp_ready;
      v.exp_id        = exp_id;
      v.exp_out       = exp_out;
      v.exp_idle      = (exp_out == 3'd0);
      v.exp_err       = exp_err;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s vec %0d: got %h expected %h", name, vec_idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge and queue what the outputs must show.
   task automatic applyStimulus(input vec_t v);
      @(negedge i_clk);
      i_rst_n         = v.rst_n;
      i_alloc_valid   = v.alloc_valid;
      i_release_valid = v.release_valid;
      i_release_id    = v.release_id;
      i_clear_error   = v.clear_error;
      scoreboard.push_back(v);
   endtask

   task automatic checkOutput();
      vec_t e;
      #1;
      n_checks++;
      if (scoreboard.size() == 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard vec %0d: got empty queue expected an entry", vec_idx);
         return;
      end
      n_checks--;
      e = scoreboard.pop_front();
      cmp("ready", 8'(o_alloc_ready), 8'(e.exp_ready));
      cmp("outstanding", 8'(o_outstanding), 8'(e.exp_out));
      cmp("idle", 8'(o_idle), 8'(e.exp_idle));
      cmp("release_error", 8'(o_release_error), 8'(e.exp_err));
      if (e.exp_ready) begin
         cmp("alloc_id", 8'(o_alloc_id), 8'(e.exp_id));
      end
      vec_idx++;
   endtask

   initial begin
      i_port_id       = 2'b10;
      i_rst_n         = 1'b0;
      i_alloc_valid   = 1'b0;
      i_release_valid = 1'b0;
      i_release_id    = 4'h0;
      i_clear_error   = 1'b0;
      repeat (2) @(posedge i_clk);

      //               alloc rel  id    clr rst  rdy  id    out   err
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h8, 3'd0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h8, 3'd0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h9, 3'd1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 3'd2, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hB, 3'd3, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h9, 3'd3, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h8, 3'd3, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 4'h8, 3'd3, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 4'h8, 3'd2, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 3'd1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 4'hA, 3'd1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 3'd0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hB, 3'd1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 4'h8, 3'd2, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 4'h8, 3'd1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h9, 3'd1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 3'd2, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 4'hB, 3'd3, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 4'hB, 3'd3, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 3'd4, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 3'd4, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd4, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 4'h0, 3'd4, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hB, 3'd3, 1'b1));
      tbl.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h8, 3'd0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h9, 3'd1, 1'b0));

      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         checkOutput();
      end

      // Refill the pool with back-to-back grants, then drain it one release per cycle.
      applyStimulus(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h9, 3'd1, 1'b0));
      checkOutput();
      applyStimulus(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 3'd2, 1'b0));
      checkOutput();
      applyStimulus(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hB, 3'd3, 1'b0));
      checkOutput();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mk(1'b0, 1'b1, 4'(8 + i), 1'b0, 1'b1, (i != 0), 4'h8, 3'(4 - i), 1'b0));
         checkOutput();
      end
      applyStimulus(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h8, 3'd0, 1'b0));
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
